sd_spi_responder: RTL and testbench
===================================

SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on sd_clk, sd_cs and sd_mosi.
REQ-002 SHALL have port clk, input, 1 bit: system clock (40 MHz); the only clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port sd_clk, input, 1 bit: SPI clock from the master, mode 0, frequency at most clk/8.
REQ-005 SHALL have port sd_cs, input, 1 bit: chip select, active-low.
REQ-006 SHALL have port sd_mosi, input, 1 bit: master-to-responder serial data.
REQ-007 SHALL have port sd_miso, output, 1 bit: responder-to-master serial data.
REQ-008 SHALL have port rd_en, output, 1 bit: one-cycle read strobe to the block buffer.
REQ-009 SHALL have port rd_addr, output, 9 bits: byte address within the 512-byte block.
REQ-010 SHALL have port rd_data, input, 8 bits: buffer data, valid the clk cycle after rd_en.
REQ-011 SHALL have port cmd_valid, output, 1 bit: one-cycle pulse when a command frame completes.
REQ-012 SHALL have port cmd_idx, output, 6 bits: index of the last command.
REQ-013 SHALL have port cmd_arg, output, 32 bits: argument of the last command.

Function
REQ-014 SHALL pass each SPI input through SYNC_STAGES flops and SHALL detect sd_clk rising and falling edges in the clk domain.
REQ-015 SHALL sample sd_mosi on each rising edge and shift it MSB first; 8 rising edges after sd_cs falls make a byte boundary, and every 8 rising edges after that make the next boundary.
REQ-016 SHALL, on the falling edge after each byte boundary, drive bit 7 of the next transmit byte on sd_miso, and bits 6..0 on the next 7 falling edges.
REQ-017 SHALL drive sd_miso = 1 whenever sd_cs is high and whenever the transmit byte is 0xFF filler.
REQ-018 SHALL use states HUNT, CMD, NCR, RESP, GAP, TOKEN, DATA, CRC.
REQ-019 HUNT: transmit 0xFF; on a received byte with bits[7:6] = 01, capture bits[5:0] as the index and go to CMD.
REQ-020 CMD: receive 5 more bytes (4 argument bytes, MSB first, then 1 CRC byte, which is ignored); after the last of these, pulse cmd_valid, update cmd_idx and cmd_arg, and go to NCR.
REQ-021 NCR: transmit one 0xFF byte, then go to RESP.
REQ-022 RESP: transmit R1 as follows.
  - CMD0: 0x01, and set the idle flag.
  - CMD1 or CMD41: 0x00, and clear the idle flag.
  - CMD17, CMD16, CMD55: {7'b0, idle}.
  - Any other index: {5'b0, 1'b1, 1'b0, idle} (illegal command).
REQ-023 After RESP, SHALL go to GAP if the command was CMD17 with idle = 0; otherwise it SHALL go to HUNT.
REQ-024 GAP: transmit one 0xFF byte. TOKEN: transmit 0xFE. DATA: transmit 512 bytes in order from buffer address 0 to 511. CRC: transmit 0xFF, 0xFF, then go to HUNT.
REQ-025 SHALL pulse rd_en, with rd_addr = n, in the clk cycle of the byte boundary that loads the byte before data byte n; rd_data SHALL be registered the next cycle.
REQ-026 CMD17 while idle = 1 SHALL return R1 = 0x01 and SHALL send no data phase.
REQ-027 SHALL ignore sd_mosi content in all states except HUNT and CMD.
REQ-028 rd_addr SHALL stop at 511 and SHALL NOT wrap within a block.
REQ-029 sd_cs rising in any state SHALL abort to HUNT within 1 clk cycle, clear the bit and byte counters, leave the idle flag unchanged, and issue no further rd_en.
REQ-030 A falling edge on sd_cs SHALL restart byte alignment at 0.

Reset
REQ-031 While rst is high, SHALL hold state = HUNT, sd_miso = 1, rd_en = 0, rd_addr = 0, cmd_valid = 0, cmd_idx = 0, cmd_arg = 0, idle flag = 1, all counters and synchronizers = idle values (sd_cs = 1, sd_clk = 0).
REQ-032 Reset asserted mid-transfer SHALL take priority over all events in the same cycle.

Verification
REQ-033 After reset, clock in 40 00 00 00 00 95 then FF FF -> cmd_valid pulses once with cmd_idx = 0 and cmd_arg = 0; MISO bytes returned are FF, 01.
REQ-034 Send CMD17 while idle -> R1 = 0x01, no FE token, no rd_en pulses, then HUNT.
REQ-035 Send CMD41 (R1 = 00), then 51 00 00 02 00 FF, with the buffer pattern byte[n] = n[7:0] -> MISO sequence FF, 00, FF, FE, 00..FF..FF (512 bytes), FF, FF; exactly 512 rd_en pulses, addresses 0..511.
REQ-036 Send 7F 00 00 00 00 01 when not idle -> R1 = 0x04; when idle -> 0x05.
REQ-037 Raise sd_cs during data byte 100 -> sd_miso = 1 within 1 cycle, rd_en stops; lowering sd_cs and sending CMD0 -> response FF, 01.
REQ-038 Assert rst during the TOKEN state -> all outputs at their reset values in the next cycle; the next CMD0 gets a normal response.

Source files
------------

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: frames 6-byte commands, answers with R1, and
// streams a 512-byte block from an external buffer after a CMD17.
module sd_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sd_clk,
  input  logic        sd_cs,
  input  logic        sd_mosi,
  output logic        sd_miso,
  output logic        rd_en,
  output logic [8:0]  rd_addr,
  input  logic [7:0]  rd_data,
  output logic        cmd_valid,
  output logic [5:0]  cmd_idx,
  output logic [31:0] cmd_arg
);

  // state | meaning
  // HUNT  | send 0xFF, wait for a byte starting with 2'b01
  // CMD   | collect 4 argument bytes and the CRC byte
  // NCR   | one 0xFF byte before the response
  // RESP  | R1 byte on the wire
  // GAP   | one 0xFF byte before the start token
  // TOKEN | 0xFE start token on the wire
  // DATA  | 512 block bytes on the wire
  // CRC   | two 0xFF CRC bytes, then back to HUNT
  typedef enum logic [2:0] {
    HUNT, CMD, NCR, RESP, GAP, TOKEN, DATA, CRC
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] clk_sync, cs_sync, mosi_sync;
  logic        clk_s, cs_s, mosi_s, clk_d;
  logic        sck_rise, sck_fall, boundary;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_shift;
  logic [7:0]  rx_byte, tx_shift, tx_n, r1, data_q;
  logic        miso_q, idle, rd_fire, rd_pend;
  logic [8:0]  byte_left, addr_q;
  logic [5:0]  idx_q;
  logic [31:0] arg_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      clk_d     <= 1'b0;
    end else begin
      clk_sync[0]  <= sd_clk;
      cs_sync[0]   <= sd_cs;
      mosi_sync[0] <= sd_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sync[i]  <= clk_sync[i-1];
        cs_sync[i]   <= cs_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
      end
      clk_d <= clk_s;
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = clk_s & ~clk_d & ~cs_s;
  assign sck_fall = ~clk_s & clk_d & ~cs_s;
  assign boundary = sck_rise & (bit_cnt == 3'd0);
  assign rx_byte  = {rx_shift, mosi_s};

  assign sd_miso = rst | cs_s | miso_q;
  assign rd_en   = rd_fire & ~rst;
  assign rd_addr = addr_q;

  always_comb begin
    r1 = {5'b0, 1'b1, 1'b0, idle};
    case (cmd_idx)
      6'd0:                r1 = 8'h01;
      6'd1, 6'd41:         r1 = 8'h00;
      6'd16, 6'd17, 6'd55: r1 = {7'b0, idle};
      default:             ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_n;
  end

  // The byte loaded at a boundary is the one for the state being entered.
  always_comb begin
    state_n = state;
    tx_n    = 8'hFF;
    rd_fire = 1'b0;
    if (cs_s) begin
      state_n = HUNT;
    end else if (boundary) begin
      case (state)
        HUNT:  if (rx_byte[7:6] == 2'b01) state_n = CMD;
        CMD:   if (byte_left == 9'd0) state_n = NCR;
        NCR: begin
          state_n = RESP;
          tx_n    = r1;
        end
        RESP:  state_n = (cmd_idx == 6'd17 && !idle) ? GAP : HUNT;
        GAP: begin
          state_n = TOKEN;
          tx_n    = 8'hFE;
          rd_fire = 1'b1;
        end
        TOKEN: begin
          state_n = DATA;
          tx_n    = data_q;
          rd_fire = 1'b1;
        end
        DATA: begin
          if (byte_left == 9'd0) begin
            state_n = CRC;
          end else begin
            tx_n    = data_q;
            rd_fire = (byte_left > 9'd1);
          end
        end
        CRC:   if (byte_left == 9'd0) state_n = HUNT;
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= 3'd7;
      rx_shift  <= '0;
      tx_shift  <= 8'hFF;
      miso_q    <= 1'b1;
      byte_left <= '0;
      idx_q     <= '0;
      arg_shift <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_pend   <= 1'b0;
      idle      <= 1'b1;
      cmd_valid <= 1'b0;
      cmd_idx   <= '0;
      cmd_arg   <= '0;
    end else begin
      cmd_valid <= 1'b0;
      rd_pend   <= rd_en;
      if (rd_pend) data_q <= rd_data;
      if (cs_s) begin
        bit_cnt   <= 3'd7;
        byte_left <= '0;
        tx_shift  <= 8'hFF;
        miso_q    <= 1'b1;
      end else begin
        // bit_cnt wraps 0 -> 7 on its own at each byte boundary
        if (sck_rise) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt - 3'd1;
        end
        if (boundary) begin
          tx_shift <= tx_n;
          case (state)
            HUNT: begin
              if (rx_byte[7:6] == 2'b01) begin
                idx_q     <= rx_byte[5:0];
                byte_left <= 9'd4;
              end
            end
            CMD: begin
              if (byte_left == 9'd0) begin
                cmd_valid <= 1'b1;
                cmd_idx   <= idx_q;
                cmd_arg   <= arg_shift;
              end else begin
                arg_shift <= {arg_shift[23:0], rx_byte};
                byte_left <= byte_left - 9'd1;
              end
            end
            NCR: begin
              if (cmd_idx == 6'd0) idle <= 1'b1;
              else if (cmd_idx == 6'd1 || cmd_idx == 6'd41) idle <= 1'b0;
            end
            RESP:  if (state_n == GAP) addr_q <= '0;
            TOKEN: byte_left <= 9'd511;
            DATA: begin
              if (byte_left == 9'd0) byte_left <= 9'd1;
              else                   byte_left <= byte_left - 9'd1;
            end
            CRC:   if (byte_left != 9'd0) byte_left <= byte_left - 9'd1;
            default: ;
          endcase
        end else if (sck_fall) begin
          miso_q   <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b1};
        end
        if (rd_fire && addr_q != 9'd511) addr_q <= addr_q + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: a bit-banged SPI master plus a
// buffer model whose byte n reads back as n[7:0].
`timescale 1ns/1ps
module tb_sd_spi_responder;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        rst, sd_clk, sd_cs, sd_mosi, sd_miso, rd_en, cmd_valid;
  logic [8:0]  rd_addr;
  logic [7:0]  rd_data = 8'hA5;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;

  int n_checks = 0, n_fail = 0;
  int cv_cnt = 0, rd_cnt = 0, addr_err = 0, rd_next = 0;

  typedef struct {
    logic [47:0] frame;
    logic [7:0]  r1;
    logic [5:0]  idx;
    logic [31:0] arg;
  } vec_t;

  vec_t vecs [12];

  always #12.5 clk = ~clk;

  sd_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sd_clk(sd_clk), .sd_cs(sd_cs), .sd_mosi(sd_mosi),
    .sd_miso(sd_miso), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .cmd_valid(cmd_valid), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg)
  );

  // buffer model: data valid only in the cycle after rd_en
  always @(posedge clk) rd_data <= rd_en ? rd_addr[7:0] : 8'hA5;

  always @(negedge clk) begin
    if (cmd_valid) cv_cnt++;
    if (rd_en) begin
      if (rd_addr !== 9'(rd_next)) addr_err++;
      rd_next++;
      rd_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    @(negedge clk);
    sd_mosi = b;
    repeat (HALF - 1) @(negedge clk);
    r = sd_miso;
    sd_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    sd_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], rb);
      r[i] = rb;
    end
  endtask

  task automatic run_cmd(input logic [47:0] f, input logic [7:0] r1_exp,
                         input logic [5:0] idx_exp, input logic [31:0] arg_exp);
    logic [7:0] r, acc;
    int cv0;
    cv0 = cv_cnt;
    acc = 8'hFF;
    for (int j = 0; j < 6; j++) begin
      spi_byte(f[47-8*j -: 8], r);
      acc = acc & r;
    end
    check("frame_miso", {24'b0, acc}, 32'hFF);
    spi_byte(8'hFF, r);
    check("ncr_byte", {24'b0, r}, 32'hFF);
    spi_byte(8'hFF, r);
    check("r1_byte", {24'b0, r}, {24'b0, r1_exp});
    check("cmd_valid_pulses", cv_cnt - cv0, 1);
    check("cmd_idx", {26'b0, cmd_idx}, {26'b0, idx_exp});
    check("cmd_arg", cmd_arg, arg_exp);
  endtask

  initial begin
    logic [7:0] r, r2, acc;
    logic       rb;
    logic [7:0] junk [5];
    int rd0, cv0, data_err;

    vecs[0]  = '{48'h40_00_00_00_00_95, 8'h01, 6'd0,  32'h0000_0000};
    vecs[1]  = '{48'h51_00_00_02_00_FF, 8'h01, 6'd17, 32'h0000_0200};
    vecs[2]  = '{48'h7F_00_00_00_00_01, 8'h05, 6'd63, 32'h0000_0000};
    vecs[3]  = '{48'h77_00_00_00_00_65, 8'h01, 6'd55, 32'h0000_0000};
    vecs[4]  = '{48'h69_40_00_00_00_77, 8'h00, 6'd41, 32'h4000_0000};
    vecs[5]  = '{48'h7F_00_00_00_00_01, 8'h04, 6'd63, 32'h0000_0000};
    vecs[6]  = '{48'h50_00_00_02_00_FF, 8'h00, 6'd16, 32'h0000_0200};
    vecs[7]  = '{48'h48_00_00_01_AA_87, 8'h04, 6'd8,  32'h0000_01AA};
    vecs[8]  = '{48'h41_12_34_56_78_FF, 8'h00, 6'd1,  32'h1234_5678};
    vecs[9]  = '{48'h40_00_00_00_00_95, 8'h01, 6'd0,  32'h0000_0000};
    vecs[10] = '{48'h51_00_00_02_00_FF, 8'h01, 6'd17, 32'h0000_0200};
    vecs[11] = '{48'h69_00_00_00_00_E5, 8'h00, 6'd41, 32'h0000_0000};
    junk[0] = 8'hFF; junk[1] = 8'h00; junk[2] = 8'h80; junk[3] = 8'hC0; junk[4] = 8'h3F;

    rst = 1'b1; sd_clk = 1'b0; sd_cs = 1'b1; sd_mosi = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_miso", {31'b0, sd_miso}, 1);
    check("rst_rd_en", {31'b0, rd_en}, 0);
    check("rst_rd_addr", {23'b0, rd_addr}, 0);
    check("rst_cmd_valid", {31'b0, cmd_valid}, 0);
    check("rst_cmd_idx", {26'b0, cmd_idx}, 0);
    check("rst_cmd_arg", cmd_arg, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("cs_high_miso", {31'b0, sd_miso}, 1);
    sd_cs = 1'b0;
    repeat (4) @(negedge clk);

    acc = 8'hFF;
    for (int j = 0; j < 5; j++) begin
      spi_byte(junk[j], r);
      acc = acc & r;
    end
    check("hunt_junk_miso", {24'b0, acc}, 32'hFF);
    check("hunt_junk_no_cmd", cv_cnt, 0);

    for (int k = 0; k < 12; k++) begin
      rd0 = rd_cnt;
      run_cmd(vecs[k].frame, vecs[k].r1, vecs[k].idx, vecs[k].arg);
      spi_byte(8'hFF, r);
      spi_byte(8'hFF, r2);
      check("post_resp_no_token", {16'b0, r, r2}, 32'hFFFF);
      check("post_resp_no_rd", rd_cnt - rd0, 0);
    end

    // full block read, idle already cleared by CMD41
    rd_next = 0; addr_err = 0; rd0 = rd_cnt;
    run_cmd(48'h51_00_00_02_00_FF, 8'h00, 6'd17, 32'h0000_0200);
    spi_byte(8'hFF, r);
    check("gap_byte", {24'b0, r}, 32'hFF);
    spi_byte(8'hFF, r);
    check("token_byte", {24'b0, r}, 32'hFE);
    data_err = 0;
    for (int n = 0; n < 512; n++) begin
      spi_byte(8'h40, r);
      if (r !== 8'(n)) data_err++;
    end
    check("data_bytes_wrong", data_err, 0);
    spi_byte(8'hFF, r);
    spi_byte(8'hFF, r2);
    check("crc_bytes", {16'b0, r, r2}, 32'hFFFF);
    check("rd_en_pulses", rd_cnt - rd0, 512);
    check("rd_addr_order_err", addr_err, 0);
    check("rd_addr_held", {23'b0, rd_addr}, 511);
    spi_byte(8'hFF, r);
    check("after_block_hunt", {24'b0, r}, 32'hFF);

    // abort inside data byte 100
    rd_next = 0; addr_err = 0; rd0 = rd_cnt; cv0 = cv_cnt;
    run_cmd(48'h51_00_00_00_00_FF, 8'h00, 6'd17, 32'h0000_0000);
    spi_byte(8'hFF, r);
    spi_byte(8'hFF, r);
    check("abort_token", {24'b0, r}, 32'hFE);
    data_err = 0;
    for (int n = 0; n < 100; n++) begin
      spi_byte(8'hFF, r);
      if (r !== 8'(n)) data_err++;
    end
    check("abort_data_wrong", data_err, 0);
    for (int j = 0; j < 4; j++) spi_bit(1'b1, rb);
    @(negedge clk);
    sd_cs = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_miso", {31'b0, sd_miso}, 1);
    check("abort_rd_cnt", rd_cnt - rd0, 102);
    for (int j = 0; j < 16; j++) spi_bit(1'b0, rb);
    check("abort_rd_stopped", rd_cnt - rd0, 102);
    check("abort_miso_held", {31'b0, sd_miso}, 1);
    check("abort_addr_err", addr_err, 0);
    check("abort_no_cmd", cv_cnt - cv0, 1);
    @(negedge clk);
    sd_cs = 1'b0;
    repeat (4) @(negedge clk);
    run_cmd(48'h77_00_00_00_00_65, 8'h00, 6'd55, 32'h0000_0000);
    run_cmd(48'h40_00_00_00_00_95, 8'h01, 6'd0, 32'h0000_0000);

    // reset while the token byte is on the wire
    run_cmd(48'h69_00_00_00_00_E5, 8'h00, 6'd41, 32'h0000_0000);
    run_cmd(48'h51_00_00_00_00_FF, 8'h00, 6'd17, 32'h0000_0000);
    spi_byte(8'hFF, r);
    check("pre_rst_gap", {24'b0, r}, 32'hFF);
    for (int j = 0; j < 3; j++) spi_bit(1'b1, rb);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("tok_rst_miso", {31'b0, sd_miso}, 1);
    check("tok_rst_rd_en", {31'b0, rd_en}, 0);
    check("tok_rst_rd_addr", {23'b0, rd_addr}, 0);
    check("tok_rst_cmd_valid", {31'b0, cmd_valid}, 0);
    check("tok_rst_cmd_idx", {26'b0, cmd_idx}, 0);
    check("tok_rst_cmd_arg", cmd_arg, 0);
    repeat (2) @(negedge clk);
    sd_clk = 1'b0;
    sd_cs = 1'b1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    sd_cs = 1'b0;
    repeat (4) @(negedge clk);
    run_cmd(48'h40_00_00_00_00_95, 8'h01, 6'd0, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
